td4_sequencer: RTL and testbench

TD4_SEQUENCER -- requirements
Module: td4_sequencer

---
 rtl/td4_sequencer.sv | 115 +++++++++++
 tb/tb_td4_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/td4_sequencer.sv
// TD4-style 4-bit sequencer: HALT/FETCH/EXEC control around a tiny
// accumulator datapath with a req/ack instruction fetch port.
module td4_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       step,
   output logic       imem_req,
   output logic [3:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   input  logic [3:0] in_port,
   output logic [3:0] out_port,
   output logic [3:0] pc,
   output logic       halted
);

   typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC} state_t;

   state_t     r_state;
   logic [3:0] r_a, r_b, r_out, r_pc;
   logic       r_c;
   logic [7:0] r_ir;
   logic       r_req, r_halted;

   logic [3:0] w_op, w_im, w_src;
   logic [4:0] w_sum;
   logic       w_wr_a, w_wr_b, w_wr_out, w_jmp;

   assign w_op  = r_ir[7:4];
   assign w_im  = r_ir[3:0];
   assign w_sum = {1'b0, w_src} + {1'b0, w_im};

   // Undefined opcodes fall through with src=0 and no destination, so C clears.
   always_comb begin
      w_src    = 4'd0;
      w_wr_a   = 1'b0;
      w_wr_b   = 1'b0;
      w_wr_out = 1'b0;
      w_jmp    = 1'b0;
      case (w_op)
         4'b0000: begin w_src = r_a;     w_wr_a   = 1'b1; end
         4'b0101: begin w_src = r_b;     w_wr_b   = 1'b1; end
         4'b0011: begin                  w_wr_a   = 1'b1; end
         4'b0111: begin                  w_wr_b   = 1'b1; end
         4'b0001: begin w_src = r_b;     w_wr_a   = 1'b1; end
         4'b0100: begin w_src = r_a;     w_wr_b   = 1'b1; end
         4'b0010: begin w_src = in_port; w_wr_a   = 1'b1; end
         4'b0110: begin w_src = in_port; w_wr_b   = 1'b1; end
         4'b1001: begin w_src = r_b;     w_wr_out = 1'b1; end
         4'b1011: begin                  w_wr_out = 1'b1; end
         4'b1111: begin                  w_jmp    = 1'b1; end
         4'b1110: begin                  w_jmp    = ~r_c; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_HALT;
         r_a      <= 4'd0;
         r_b      <= 4'd0;
         r_c      <= 1'b0;
         r_out    <= 4'd0;
         r_pc     <= 4'd0;
         r_ir     <= 8'd0;
         r_req    <= 1'b0;
         r_halted <= 1'b1;
      end else begin
         case (r_state)
            S_HALT: begin
               if (run || step) begin
                  r_state  <= S_FETCH;
                  r_req    <= 1'b1;
                  r_halted <= 1'b0;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_ir    <= imem_data;
                  r_state <= S_EXEC;
                  r_req   <= 1'b0;
               end
            end
            S_EXEC: begin
               if (w_wr_a)   r_a   <= w_sum[3:0];
               if (w_wr_b)   r_b   <= w_sum[3:0];
               if (w_wr_out) r_out <= w_sum[3:0];
               r_c  <= w_sum[4];
               r_pc <= w_jmp ? w_sum[3:0] : r_pc + 4'd1;
               // run is re-sampled here, so a step-started instruction ends halted
               if (run) begin
                  r_state <= S_FETCH;
                  r_req   <= 1'b1;
               end else begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end
            end
            default: begin
               r_state  <= S_HALT;
               r_req    <= 1'b0;
               r_halted <= 1'b1;
            end
         endcase
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign out_port  = r_out;
   assign halted    = r_halted;

endmodule

// File: tb/tb_td4_sequencer.sv
// Scoreboard bench for td4_sequencer: an ISA model predicts pc/out/halted per
// acknowledged fetch; predictions are popped when the EXEC cycle completes.
module tb_td4_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       imem_req;
   logic [3:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_data = 8'h00;
   logic [3:0] in_port = 4'h0;
   logic [3:0] out_port;
   logic [3:0] pc;
   logic       halted;

   td4_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .in_port(in_port), .out_port(out_port),
      .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] pc;
      logic [3:0] out;
      logic       halted;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] rom [0:15];
   logic [3:0] mA, mB, mOut, mPc;
   logic       mC;
   int         n_chk = 0;
   int         n_bad = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mA = 4'd0; mB = 4'd0; mC = 1'b0; mOut = 4'd0; mPc = 4'd0;
   endtask

   // Reference ISA: src + im, carry always updated, JNC tests the old carry.
   task automatic model_exec(input logic [7:0] ins);
      logic [3:0] op, im, src;
      logic [4:0] s;
      int         dst;
      op = ins[7:4]; im = ins[3:0]; src = 4'd0; dst = 0;
      case (op)
         4'h0: begin src = mA; dst = 1; end
         4'h5: begin src = mB; dst = 2; end
         4'h3: dst = 1;
         4'h7: dst = 2;
         4'h1: begin src = mB; dst = 1; end
         4'h4: begin src = mA; dst = 2; end
         4'h2: begin src = in_port; dst = 1; end
         4'h6: begin src = in_port; dst = 2; end
         4'h9: begin src = mB; dst = 3; end
         4'hB: dst = 3;
         4'hF: dst = 4;
         4'hE: dst = mC ? 0 : 4;
         default: dst = 0;
      endcase
      s = {1'b0, src} + {1'b0, im};
      mC = s[4];
      if (dst == 1) mA = s[3:0];
      if (dst == 2) mB = s[3:0];
      if (dst == 3) mOut = s[3:0];
      mPc = (dst == 4) ? s[3:0] : mPc + 4'd1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", imem_req, 1'b1);
   endtask

   // One fetch/exec: optional wait states, run dropped in FETCH, or a stray step in FETCH.
   task automatic do_instr(input int waits, input bit drop_run, input bit pulse_step);
      exp_t e;
      wait_req();
      chk("fetch_addr", imem_addr, mPc);
      if (drop_run) run = 1'b0;
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         if (pulse_step && i == 0) step = 1'b1;
         tick();
         step = 1'b0;
         chk("wait_req", imem_req, 1'b1);
         chk("wait_addr", imem_addr, mPc);
         chk("wait_out", out_port, mOut);
      end
      imem_ack  = 1'b1;
      imem_data = rom[mPc];
      model_exec(rom[mPc]);
      sb.push_back('{pc: mPc, out: mOut, halted: !run});
      tick();
      imem_ack  = 1'b0;
      imem_data = 8'h00;
      chk("exec_req", imem_req, 1'b0);
      tick();
      if (sb.size() == 0) begin
         chk("sb_empty", 1'b1, 1'b0);
      end else begin
         e = sb.pop_front();
         chk("pc", pc, e.pc);
         chk("out", out_port, e.out);
         chk("halted", halted, e.halted);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_pc", pc, 4'd0);
      chk("rst_out", out_port, 4'd0);
      chk("rst_halted", halted, 1'b1);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      rom = '{default: 8'h00};
      tick();
      chk("por_req", imem_req, 1'b0);
      chk("por_pc", pc, 4'd0);
      chk("por_out", out_port, 4'd0);
      chk("por_halted", halted, 1'b1);
      reset = 1'b0;
      tick(); tick();
      chk("idle_halted", halted, 1'b1);
      chk("idle_req", imem_req, 1'b0);

      // Back-to-back run, ends with JMP 0.
      rom[0] = 8'h33; rom[1] = 8'h04; rom[2] = 8'h90; rom[3] = 8'hF0;
      run = 1'b1;
      for (int i = 0; i < 4; i++) do_instr(0, i == 3, 1'b0);

      // Carry, JNC not taken, OUT Im, JMP, then JNC taken; one fetch stalls 3 cycles.
      rom = '{default: 8'h00};
      rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE5; rom[3] = 8'hB9;
      rom[4] = 8'h00; rom[5] = 8'hFF; rom[15] = 8'hF2;
      run = 1'b1;
      for (int i = 0; i < 8; i++) do_instr((i == 4) ? 3 : 0, i == 7, 1'b0);
      chk("jnc_taken_pc", pc, 4'd5);

      // Single step with a second step pulse during FETCH.
      pulse_reset();
      rom = '{default: 8'h00};
      rom[0] = 8'h35; rom[1] = 8'h40; rom[2] = 8'h90;
      step = 1'b1; tick(); step = 1'b0;
      do_instr(2, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      chk("step_hold_pc", pc, 4'd1);
      chk("step_hold_halted", halted, 1'b1);
      chk("step_hold_req", imem_req, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step = 1'b1; tick(); step = 1'b0;
         do_instr(0, 1'b0, 1'b0);
      end
      chk("step_out", out_port, 4'd5);

      // Undefined opcode clears C (JNC then taken), IN A reads in_port.
      rom[3] = 8'h3F; rom[4] = 8'h01; rom[5] = 8'h8A; rom[6] = 8'hE9;
      rom[9] = 8'h21; rom[10] = 8'h40; rom[11] = 8'h90;
      in_port = 4'h6;
      run = 1'b1;
      for (int i = 0; i < 7; i++) do_instr(0, i == 6, 1'b0);
      chk("in_out", out_port, 4'd7);

      // Reset during a fetch wait, then a stray ack while halted.
      run = 1'b1;
      wait_req();
      imem_ack = 1'b0;
      tick(); tick();
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_req", imem_req, 1'b0);
      chk("midrst_pc", pc, 4'd0);
      chk("midrst_out", out_port, 4'd0);
      chk("midrst_halted", halted, 1'b1);
      run = 1'b0;
      tick();
      reset = 1'b0;
      imem_ack = 1'b1; imem_data = 8'h35;
      tick(); tick(); tick();
      chk("ack_ign_halted", halted, 1'b1);
      chk("ack_ign_pc", pc, 4'd0);
      chk("ack_ign_req", imem_req, 1'b0);
      chk("ack_ign_out", out_port, 4'd0);
      imem_ack = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
